// File: rtl/game_flow_ctrl_if.sv
// Game-flow bus: per-frame event inputs and the game status outputs.
// The testbench drives the master side; the controller is the slave.
interface game_flow_ctrl_if;
   logic       frame_tick;
   logic       start;
   logic       hit;
   logic       goal;
   logic [1:0] state;
   logic       step_en;
   logic       player_rst;
   logic [2:0] level;
   logic [1:0] lives;
   logic [7:0] score;

   modport master (
      output frame_tick, start, hit, goal,
      input  state, step_en, player_rst, level, lives, score
   );

   modport slave (
      input  frame_tick, start, hit, goal,
      output state, step_en, player_rst, level, lives, score
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow controller: start/play/dying/over sequencing, obstacle step
// timing from frame ticks, and level/lives/score bookkeeping.
module game_flow_ctrl #(
   parameter int START_LIVES  = 3,
   parameter int MAX_LEVEL    = 7,
   parameter int BASE_DIV     = 30,
   parameter int DIV_STEP     = 4,
   parameter int DEATH_FRAMES = 60
) (
   input  logic              vga_clk,
   input  logic              reset,
   game_flow_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PLAY  = 2'b01,
      DYING = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t      state_q;
   logic        step_q;
   logic        prst_q;
   logic [2:0]  level_q;
   logic [1:0]  lives_q;
   logic [7:0]  score_q;
   logic [5:0]  fcnt_q;
   logic        hit_h_q;
   logic        goal_h_q;

   logic        hit_rise;
   logic        goal_rise;
   logic [5:0]  fcnt_inc;
   logic [5:0]  div;
   logic [11:0] sub;

   assign hit_rise  = bus.hit  & ~hit_h_q;
   assign goal_rise = bus.goal & ~goal_h_q;
   assign fcnt_inc  = fcnt_q + 6'd1;

   // Step interval shrinks with level; floor of 2 avoids underflow.
   always_comb begin
      sub = 12'(DIV_STEP) * 12'(level_q);
      div = 6'd2;
      if (12'(BASE_DIV) >= sub + 12'd2)
         div = 6'(12'(BASE_DIV) - sub);
   end

   // Game FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_q  <= IDLE;
         step_q   <= 1'b0;
         prst_q   <= 1'b0;
         level_q  <= 3'd0;
         lives_q  <= 2'(START_LIVES);
         score_q  <= 8'd0;
         fcnt_q   <= 6'd0;
         hit_h_q  <= 1'b0;
         goal_h_q <= 1'b0;
      end else begin
         hit_h_q  <= bus.hit;
         goal_h_q <= bus.goal;
         step_q   <= 1'b0;
         prst_q   <= 1'b0;
         unique case (state_q)
            IDLE, OVER: begin
               if (bus.start) begin
                  lives_q <= 2'(START_LIVES);
                  level_q <= 3'd0;
                  score_q <= 8'd0;
                  fcnt_q  <= 6'd0;
                  prst_q  <= 1'b1;
                  state_q <= PLAY;
               end
            end
            PLAY: begin
               if (hit_rise) begin
                  lives_q <= lives_q - 2'd1;
                  prst_q  <= 1'b1;
                  fcnt_q  <= 6'd0;
                  state_q <= (lives_q == 2'd1) ? OVER : DYING;
               end else if (goal_rise) begin
                  if (score_q != 8'hFF)
                     score_q <= score_q + 8'd1;
                  if (level_q < 3'(MAX_LEVEL))
                     level_q <= level_q + 3'd1;
                  prst_q <= 1'b1;
                  fcnt_q <= 6'd0;
               end else if (bus.frame_tick) begin
                  if (fcnt_inc == div) begin
                     step_q <= 1'b1;
                     fcnt_q <= 6'd0;
                  end else begin
                     fcnt_q <= fcnt_inc;
                  end
               end
            end
            DYING: begin
               if (bus.frame_tick) begin
                  if (fcnt_inc == 6'(DEATH_FRAMES)) begin
                     fcnt_q  <= 6'd0;
                     state_q <= PLAY;
                  end else begin
                     fcnt_q <= fcnt_inc;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.state      = state_q;
   assign bus.step_en    = step_q;
   assign bus.player_rst = prst_q;
   assign bus.level      = level_q;
   assign bus.lives      = lives_q;
   assign bus.score      = score_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scenario bench for game_flow_ctrl: expected results are queued as
// stimulus is driven and popped against the DUT outputs afterwards.
module tb_game_flow_ctrl;

   logic vga_clk = 1'b0;
   logic reset;

   game_flow_ctrl_if bus();

   game_flow_ctrl dut (
      .vga_clk (vga_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      string       name;
      logic [31:0] v;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   step_cnt = 0;
   int   prst_cnt = 0;
   int   s0;
   int   p0;

   always @(negedge vga_clk) begin
      if (bus.step_en === 1'b1) step_cnt++;
      if (bus.player_rst === 1'b1) prst_cnt++;
   end

   function automatic logic [31:0] pk(logic [1:0] s, logic [2:0] l,
                                      logic [1:0] li, logic [7:0] sc);
      return {17'd0, s, l, li, sc};
   endfunction

   function automatic logic [31:0] snap();
      return {17'd0, bus.state, bus.level, bus.lives, bus.score};
   endfunction

   task automatic cyc();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic tick();
      bus.frame_tick = 1'b1; cyc();
      bus.frame_tick = 1'b0; cyc();
   endtask

   task automatic pulse_goal();
      bus.goal = 1'b1; cyc();
      bus.goal = 1'b0; cyc();
   endtask

   task automatic pulse_hit();
      bus.hit = 1'b1; cyc();
      bus.hit = 1'b0; cyc();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; cyc();
      bus.start = 1'b0; cyc();
   endtask

   task automatic test_reset();
      bus.frame_tick = 0; bus.goal = 0;
      reset = 1; bus.start = 1; bus.hit = 1;
      sbq.push_back('{"reset_state", pk(2'b00, 3'd0, 2'd3, 8'd0)});
      sbq.push_back('{"reset_pulses", 32'd0});
      cyc();
      bus.start = 0; bus.hit = 0;
      cyc();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'({bus.step_en, bus.player_rst}) !== e.v) begin
         n_err++;
         $display("FAIL %s: got %b%b, expected 0",
                  e.name, bus.step_en, bus.player_rst);
      end
      reset = 0;
      cyc();
      s0 = step_cnt; p0 = prst_cnt;
      sbq.push_back('{"idle_ignores", pk(2'b00, 3'd0, 2'd3, 8'd0)});
      sbq.push_back('{"idle_no_pulse", 32'd0});
      pulse_hit(); pulse_goal();
      for (int i = 0; i < 40; i++) tick();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0 + prst_cnt - p0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d pulses, expected %0d",
                           e.name, step_cnt - s0 + prst_cnt - p0, e.v);
      end
   endtask

   task automatic test_start_steps();
      s0 = step_cnt; p0 = prst_cnt;
      sbq.push_back('{"start_state", pk(2'b01, 3'd0, 2'd3, 8'd0)});
      sbq.push_back('{"start_prst", 32'd1});
      bus.start = 1; cyc();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(bus.player_rst) !== e.v) begin
         n_err++; $display("FAIL %s: got %b, expected 1", e.name, bus.player_rst);
      end
      bus.start = 0; cyc();
      for (int i = 1; i <= 90; i++) begin
         int s1;
         s1 = step_cnt;
         sbq.push_back('{$sformatf("step_tick%0d", i), 32'(i % 30 == 0)});
         tick();
         e = sbq.pop_front(); n_cmp++;
         if (32'(step_cnt - s1) !== e.v) begin
            n_err++; $display("FAIL %s: got %0d, expected %0d",
                              e.name, step_cnt - s1, e.v);
         end
      end
      sbq.push_back('{"step_total90", 32'd3});
      sbq.push_back('{"prst_once", 32'd1});
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, step_cnt - s0, e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(prst_cnt - p0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, prst_cnt - p0, e.v);
      end
   endtask

   task automatic test_goals();
      sbq.push_back('{"goals8", pk(2'b01, 3'd7, 2'd3, 8'd8)});
      sbq.push_back('{"div2_steps", 32'd3});
      for (int i = 0; i < 8; i++) pulse_goal();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      s0 = step_cnt;
      for (int i = 0; i < 6; i++) tick();
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, step_cnt - s0, e.v);
      end
   endtask

   task automatic test_hit_held();
      s0 = step_cnt; p0 = prst_cnt;
      sbq.push_back('{"hit_first", pk(2'b10, 3'd7, 2'd2, 8'd8)});
      sbq.push_back('{"hit_held", pk(2'b10, 3'd7, 2'd2, 8'd8)});
      sbq.push_back('{"dying_59", pk(2'b10, 3'd7, 2'd2, 8'd8)});
      sbq.push_back('{"dying_60", pk(2'b01, 3'd7, 2'd2, 8'd8)});
      sbq.push_back('{"dying_no_step", 32'd0});
      sbq.push_back('{"hit_prst_once", 32'd1});
      bus.hit = 1; cyc();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      for (int i = 0; i < 99; i++) cyc();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      bus.hit = 0;
      for (int i = 0; i < 59; i++) begin
         if (i == 20) begin pulse_goal(); pulse_start(); end
         tick();
      end
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      tick();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, step_cnt - s0, e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(prst_cnt - p0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, prst_cnt - p0, e.v);
      end
   endtask

   task automatic test_hit_goal_tick();
      tick();
      s0 = step_cnt; p0 = prst_cnt;
      sbq.push_back('{"hg_state", pk(2'b10, 3'd7, 2'd1, 8'd8)});
      sbq.push_back('{"hg_pulses", 32'b01});
      sbq.push_back('{"hg_prst_once", 32'd1});
      bus.frame_tick = 1; bus.hit = 1; bus.goal = 1;
      cyc();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'({bus.step_en, bus.player_rst}) !== e.v) begin
         n_err++; $display("FAIL %s: got %b%b, expected 01",
                           e.name, bus.step_en, bus.player_rst);
      end
      bus.frame_tick = 0; bus.hit = 0; bus.goal = 0;
      for (int i = 0; i < 60; i++) tick();
      e = sbq.pop_front(); n_cmp++;
      if (32'(prst_cnt - p0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, prst_cnt - p0, e.v);
      end
   endtask

   task automatic test_game_over();
      logic [31:0] hexp [3];
      hexp[0] = pk(2'b10, 3'd0, 2'd2, 8'd0);
      hexp[1] = pk(2'b10, 3'd0, 2'd1, 8'd0);
      hexp[2] = pk(2'b11, 3'd0, 2'd0, 8'd0);
      sbq.push_back('{"last_hit_over", pk(2'b11, 3'd7, 2'd0, 8'd8)});
      sbq.push_back('{"over_hold", pk(2'b11, 3'd7, 2'd0, 8'd8)});
      sbq.push_back('{"over_no_pulse", 32'd0});
      pulse_hit();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      s0 = step_cnt; p0 = prst_cnt;
      for (int i = 0; i < 10; i++) tick();
      pulse_goal(); pulse_hit();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0 + prst_cnt - p0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d",
                           e.name, step_cnt - s0 + prst_cnt - p0, e.v);
      end
      sbq.push_back('{"restart", pk(2'b01, 3'd0, 2'd3, 8'd0)});
      pulse_start();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      for (int h = 0; h < 3; h++) begin
         sbq.push_back('{$sformatf("hit%0d", h + 1), hexp[h]});
         pulse_hit();
         e = sbq.pop_front(); n_cmp++;
         if (snap() !== e.v) begin
            n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
         end
         if (h < 2) for (int i = 0; i < 60; i++) tick();
      end
      sbq.push_back('{"restart2", pk(2'b01, 3'd0, 2'd3, 8'd0)});
      pulse_start();
      p0 = prst_cnt;
      pulse_start();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v || prst_cnt != p0) begin
         n_err++; $display("FAIL %s: got %h prst+%0d, expected %h prst+0",
                           e.name, snap(), prst_cnt - p0, e.v);
      end
   endtask

   task automatic test_reset_dying();
      sbq.push_back('{"dying_s5", pk(2'b10, 3'd5, 2'd2, 8'd5)});
      sbq.push_back('{"rst_dying", pk(2'b00, 3'd0, 2'd3, 8'd0)});
      sbq.push_back('{"post_rst_quiet", 32'd0});
      for (int i = 0; i < 5; i++) pulse_goal();
      pulse_hit();
      for (int i = 0; i < 10; i++) tick();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      reset = 1; bus.frame_tick = 1; bus.hit = 1;
      cyc();
      reset = 0; bus.frame_tick = 0; bus.hit = 0;
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
      s0 = step_cnt; p0 = prst_cnt;
      for (int i = 0; i < 70; i++) tick();
      pulse_hit(); pulse_goal();
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0 + prst_cnt - p0) !== e.v || bus.state !== 2'b00) begin
         n_err++; $display("FAIL %s: got %0d pulses state %b, expected 0 state 00",
                           e.name, step_cnt - s0 + prst_cnt - p0, bus.state);
      end
   endtask

   task automatic test_level1_and_sat();
      pulse_start();
      pulse_goal();
      s0 = step_cnt;
      sbq.push_back('{"lvl1_25ticks", 32'd0});
      sbq.push_back('{"lvl1_26th", 32'd1});
      sbq.push_back('{"score_sat", pk(2'b01, 3'd7, 2'd3, 8'd255)});
      for (int i = 0; i < 25; i++) tick();
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, step_cnt - s0, e.v);
      end
      tick();
      e = sbq.pop_front(); n_cmp++;
      if (32'(step_cnt - s0) !== e.v) begin
         n_err++; $display("FAIL %s: got %0d, expected %0d", e.name, step_cnt - s0, e.v);
      end
      for (int i = 0; i < 259; i++) pulse_goal();
      e = sbq.pop_front(); n_cmp++;
      if (snap() !== e.v) begin
         n_err++; $display("FAIL %s: got %h, expected %h", e.name, snap(), e.v);
      end
   endtask

   initial begin
      bus.frame_tick = 0; bus.start = 0; bus.hit = 0; bus.goal = 0;
      reset = 1;
      cyc();
      test_reset();
      test_start_steps();
      test_goals();
      test_hit_held();
      test_hit_goal_tick();
      test_game_over();
      test_reset_dying();
      test_level1_and_sat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have parameter START_LIVES, default 3: lives loaded at game start (legal range 1..3).
REQ-002 The block SHALL have parameter MAX_LEVEL, default 7: saturation value of level (at most 7).
REQ-003 The block SHALL have parameter BASE_DIV, default 30: frames per obstacle step at level 0 (legal range 2..63).
REQ-004 The block SHALL have parameter DIV_STEP, default 4: frames removed from the step interval per level.
REQ-005 The block SHALL have parameter DEATH_FRAMES, default 60: length of the death pause in frames (legal range 1..63).
REQ-006 The block SHALL have port vga_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse, once per video frame.
REQ-009 The block SHALL have port start, input, 1 bit: debounced one-cycle start-key pulse.
REQ-010 The block SHALL have port hit, input, 1 bit: player/obstacle collision, level-sensitive.
REQ-011 The block SHALL have port goal, input, 1 bit: player reached the right edge, level-sensitive.
REQ-012 The block SHALL have port state, output, 2 bits: 00 IDLE, 01 PLAY, 10 DYING, 11 OVER.
REQ-013 The block SHALL have port step_en, output, 1 bit: one-cycle pulse that advances the obstacle columns by one row.
REQ-014 The block SHALL have port player_rst, output, 1 bit: one-cycle pulse that returns the player to x=1.
REQ-015 The block SHALL have port level, output, 3 bits: current level.
REQ-016 The block SHALL have port lives, output, 2 bits: remaining lives.
REQ-017 The block SHALL have port score, output, 8 bits: goals reached in the current game.

Function
REQ-018 All outputs SHALL be registered; each event SHALL be visible on the outputs one cycle after the input cycle that caused it.
REQ-019 In IDLE, a start pulse SHALL load lives=START_LIVES, level=0, score=0 and the frame counter to 0, pulse player_rst, and move to PLAY.
REQ-020 The step interval SHALL be div = max(BASE_DIV - DIV_STEP*level, 2), computed without underflow.
REQ-021 In PLAY, each frame_tick SHALL increment the 6-bit frame counter.
REQ-022 When a frame_tick brings the frame counter to div, the block SHALL pulse step_en once and clear the counter.
REQ-023 In PLAY, a hit SHALL decrement lives and pulse player_rst; the next state SHALL be OVER if lives was 1, otherwise DYING.
REQ-024 In PLAY, a goal SHALL increment score (saturating at 255) and level (saturating at MAX_LEVEL), pulse player_rst, clear the frame counter, and stay in PLAY.
REQ-025 If hit and goal are asserted in the same cycle, hit SHALL take priority and goal SHALL be dropped.
REQ-026 If goal or hit coincides with the frame_tick that would complete the interval, the block SHALL clear the counter and SHALL NOT pulse step_en.
REQ-027 A new level SHALL take effect on the interval beginning immediately after the goal.
REQ-028 Hit and goal SHALL be edge-qualified: an event is taken only on a 0->1 transition sampled in PLAY, so a held hit costs exactly one life.
REQ-029 In DYING, step_en SHALL be suppressed and DEATH_FRAMES frame_ticks SHALL be counted; after the last one the block SHALL return to PLAY with the frame counter cleared.
REQ-030 In DYING, hit and goal SHALL be ignored.
REQ-031 In OVER, step_en SHALL be suppressed, score and level SHALL be held, and lives SHALL read 0.
REQ-032 In OVER, a start pulse SHALL behave exactly as start in IDLE (REQ-019).
REQ-033 Start SHALL be ignored in PLAY and DYING; hit and goal SHALL be ignored in IDLE and OVER.
REQ-034 step_en and player_rst SHALL never assert in IDLE or OVER, except the player_rst pulse on start.

Reset
REQ-035 Reset SHALL take priority over every other input, including start or hit in the same cycle.
REQ-036 On reset: state=IDLE, step_en=0, player_rst=0, level=0, lives=START_LIVES, score=0, frame counter=0, edge-detect history=0.
REQ-037 Reset asserted mid-game or mid-DYING SHALL discard all progress with no pending pulse emitted afterwards.

Verification
REQ-038 Reset, start, then 90 frame_ticks in PLAY -> state=01, player_rst pulses once, exactly 3 step_en pulses, each on the 30th tick of its interval.
REQ-039 Eight goal pulses, then 6 frame_ticks -> score=8, level=7, div=2, 3 step_en pulses.
REQ-040 Hit held high for 100 cycles with lives=3 -> lives=2, state=10, no step_en for 60 frame_ticks, then state=01.
REQ-041 Three separate hits -> states 10, 10, then 11 with lives=0; a following start -> state=01, lives=3, score=0, level=0.
REQ-042 Hit and goal asserted in the same cycle as an interval-completing frame_tick -> lives decremented, score unchanged, no step_en, player_rst pulses once.
REQ-043 Reset asserted while in DYING with score=5 -> next cycle state=00, score=0, lives=3, and no pulses thereafter until start.
